// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS pipeline: D-stage stall/E bubble and D/E/M forwarding selects.
// Optional stall statistics counter enabled with `define HAZARD_STAT_EN.
module hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int TN_W  = 2
`ifdef HAZARD_STAT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] a1_d,
    input  logic [RA_W-1:0] a2_d,
    input  logic [RA_W-1:0] a3_d,
    input  logic [TN_W-1:0] tnew_d,
    input  logic            tuse_rs0,
    input  logic            tuse_rs1,
    input  logic            tuse_rt0,
    input  logic            tuse_rt1,
    output logic            stall,
    output logic [1:0]      fwd_rs_d,
    output logic [1:0]      fwd_rt_d,
    output logic [1:0]      fwd_rs_e,
    output logic [1:0]      fwd_rt_e,
    output logic            fwd_rt_m
`ifdef HAZARD_STAT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    logic [RA_W-1:0] a1_e_q, a2_e_q, a3_e_q;
    logic [TN_W-1:0] tnew_e_q;
    logic [RA_W-1:0] a2_m_q, a3_m_q;
    logic [TN_W-1:0] tnew_m_q;
    logic [RA_W-1:0] a3_w_q;

    logic [RA_W-1:0] a1_e_d, a2_e_d, a3_e_d;
    logic [TN_W-1:0] tnew_e_d;
    logic [TN_W-1:0] tnew_m_d;

    // A destination of $0 never produces anything, so it can never match.
    function automatic logic hit(input logic [RA_W-1:0] dst, input logic [RA_W-1:0] src);
        return (dst == src) && (src != '0);
    endfunction

    function automatic logic need_stall(input logic [RA_W-1:0] src,
                                        input logic            use0,
                                        input logic            use1,
                                        input logic [RA_W-1:0] dst_e,
                                        input logic [TN_W-1:0] tn_e,
                                        input logic [RA_W-1:0] dst_m,
                                        input logic [TN_W-1:0] tn_m);
        logic s;
        s = 1'b0;
        if (use0 && hit(dst_e, src) && (tn_e >= TN_W'(1))) s = 1'b1;
        if (use0 && hit(dst_m, src) && (tn_m >= TN_W'(1))) s = 1'b1;
        if (use1 && hit(dst_e, src) && (tn_e >= TN_W'(2))) s = 1'b1;
        return s;
    endfunction

    // Closest producer decides; if it is not ready yet the select is 0 and the stall covers it.
    function automatic logic [1:0] sel_d(input logic [RA_W-1:0] src,
                                         input logic [RA_W-1:0] dst_e,
                                         input logic [TN_W-1:0] tn_e,
                                         input logic [RA_W-1:0] dst_m,
                                         input logic [TN_W-1:0] tn_m,
                                         input logic [RA_W-1:0] dst_w);
        logic [1:0] r;
        r = 2'd0;
        if (hit(dst_e, src))      r = (tn_e == '0) ? 2'd1 : 2'd0;
        else if (hit(dst_m, src)) r = (tn_m == '0) ? 2'd2 : 2'd0;
        else if (hit(dst_w, src)) r = 2'd3;
        return r;
    endfunction

    function automatic logic [1:0] sel_e(input logic [RA_W-1:0] src,
                                         input logic [RA_W-1:0] dst_m,
                                         input logic [TN_W-1:0] tn_m,
                                         input logic [RA_W-1:0] dst_w);
        logic [1:0] r;
        r = 2'd0;
        if (hit(dst_m, src) && (tn_m == '0)) r = 2'd1;
        else if (hit(dst_w, src))            r = 2'd2;
        return r;
    endfunction

    always_comb begin
        stall = need_stall(a1_d, tuse_rs0, tuse_rs1, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q)
              | need_stall(a2_d, tuse_rt0, tuse_rt1, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
        fwd_rs_d = sel_d(a1_d, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
        fwd_rt_d = sel_d(a2_d, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
        fwd_rs_e = sel_e(a1_e_q, a3_m_q, tnew_m_q, a3_w_q);
        fwd_rt_e = sel_e(a2_e_q, a3_m_q, tnew_m_q, a3_w_q);
        fwd_rt_m = hit(a3_w_q, a2_m_q);
    end

    always_comb begin
        a1_e_d   = a1_d;
        a2_e_d   = a2_d;
        a3_e_d   = a3_d;
        tnew_e_d = tnew_d;
        if (stall) begin
            a1_e_d   = '0;
            a2_e_d   = '0;
            a3_e_d   = '0;
            tnew_e_d = '0;
        end
        tnew_m_d = (tnew_e_q == '0) ? '0 : tnew_e_q - TN_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1_e_q   <= '0;
            a2_e_q   <= '0;
            a3_e_q   <= '0;
            tnew_e_q <= '0;
            a2_m_q   <= '0;
            a3_m_q   <= '0;
            tnew_m_q <= '0;
            a3_w_q   <= '0;
        end else begin
            a1_e_q   <= a1_e_d;
            a2_e_q   <= a2_e_d;
            a3_e_q   <= a3_e_d;
            tnew_e_q <= tnew_e_d;
            a2_m_q   <= a2_e_q;
            a3_m_q   <= a3_e_q;
            tnew_m_q <= tnew_m_d;
            a3_w_q   <= a3_m_q;
        end
    end

`ifdef HAZARD_STAT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     stall_cnt_q <= '0;
        else if (stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl; model keeps a history queue of instructions that entered E.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] a1_d, a2_d, a3_d;
    logic [1:0] tnew_d;
    logic       tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1;
    logic       stall;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic       fwd_rt_m;
`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt;
    logic [31:0] m_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .a1_d     (a1_d),
        .a2_d     (a2_d),
        .a3_d     (a3_d),
        .tnew_d   (tnew_d),
        .tuse_rs0 (tuse_rs0),
        .tuse_rs1 (tuse_rs1),
        .tuse_rt0 (tuse_rt0),
        .tuse_rt1 (tuse_rt1),
        .stall    (stall),
        .fwd_rs_d (fwd_rs_d),
        .fwd_rt_d (fwd_rt_d),
        .fwd_rs_e (fwd_rs_e),
        .fwd_rt_e (fwd_rt_e),
        .fwd_rt_m (fwd_rt_m)
`ifdef HAZARD_STAT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // Instruction as it entered E; index k of hist = instruction k stages past E entry.
    typedef struct {
        int a1;
        int a2;
        int a3;
        int tn;
    } instr_t;

    instr_t hist[$];

    function automatic int a_of(int k, int which);
        if (k >= hist.size()) return 0;
        return (which == 1) ? hist[k].a1 : (which == 2) ? hist[k].a2 : hist[k].a3;
    endfunction

    function automatic bit m_hit(int k, int x);
        return (x != 0) && (k < hist.size()) && (hist[k].a3 == x);
    endfunction

    function automatic int m_tn(int k);
        int t;
        if (k >= hist.size() || k >= 2) return 0;
        t = hist[k].tn - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic bit m_stall_op(int x, bit u0, bit u1);
        return (u0 && m_hit(0, x) && m_tn(0) >= 1) ||
               (u0 && m_hit(1, x) && m_tn(1) >= 1) ||
               (u1 && m_hit(0, x) && m_tn(0) >= 2);
    endfunction

    function automatic bit m_stall();
        return m_stall_op(int'(a1_d), tuse_rs0, tuse_rs1) ||
               m_stall_op(int'(a2_d), tuse_rt0, tuse_rt1);
    endfunction

    function automatic int m_fwd_d(int x);
        for (int k = 0; k < 3; k++)
            if (m_hit(k, x)) return (m_tn(k) == 0) ? k + 1 : 0;
        return 0;
    endfunction

    function automatic int m_fwd_e(int x);
        if (m_hit(1, x) && m_tn(1) == 0) return 1;
        if (m_hit(2, x)) return 2;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Model advance on every clock edge, cleared by reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist.delete();
`ifdef HAZARD_STAT_EN
            m_cnt = 0;
`endif
        end else begin
            instr_t ni;
            bit s;
            s = m_stall();
`ifdef HAZARD_STAT_EN
            if (s) m_cnt = m_cnt + 1;
`endif
            ni.a1 = s ? 0 : int'(a1_d);
            ni.a2 = s ? 0 : int'(a2_d);
            ni.a3 = s ? 0 : int'(a3_d);
            ni.tn = s ? 0 : int'(tnew_d);
            hist.push_front(ni);
            if (hist.size() > 3) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        chk("stall",    int'(stall),    int'(m_stall()));
        chk("fwd_rs_d", int'(fwd_rs_d), m_fwd_d(int'(a1_d)));
        chk("fwd_rt_d", int'(fwd_rt_d), m_fwd_d(int'(a2_d)));
        chk("fwd_rs_e", int'(fwd_rs_e), m_fwd_e(a_of(0, 1)));
        chk("fwd_rt_e", int'(fwd_rt_e), m_fwd_e(a_of(0, 2)));
        chk("fwd_rt_m", int'(fwd_rt_m), int'(m_hit(2, a_of(1, 2))));
`ifdef HAZARD_STAT_EN
        chk("stall_cnt", int'(stall_cnt), int'(m_cnt));
`endif
    end

    task automatic drive(input int a1, input int a2, input int a3, input int tn,
                         input bit rs0, input bit rs1, input bit rt0, input bit rt1);
        a1_d = 5'(a1); a2_d = 5'(a2); a3_d = 5'(a3); tnew_d = 2'(tn);
        tuse_rs0 = rs0; tuse_rs1 = rs1; tuse_rt0 = rt0; tuse_rt1 = rt1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    task automatic lw_beq();
        drive(0, 0, 8, 2, 0, 0, 0, 0); step();
        drive(8, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk); chk("lw_beq stall c1", int'(stall), 1); step();
        @(negedge clk); chk("lw_beq stall c2", int'(stall), 1); step();
        @(negedge clk); chk("lw_beq release", int'(stall), 0);
        chk("lw_beq fwd_rs_d", int'(fwd_rs_d), 3); step();
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Reset held for 3 cycles with arbitrary D inputs.
        for (int i = 0; i < 3; i++) begin
            drive($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 3), 1, 1, 1, 1);
            @(negedge clk);
            chk("rst stall", int'(stall), 0);
            chk("rst fwd_rs_d", int'(fwd_rs_d), 0);
            step();
        end
        reset = 1'b1;
        nops(3);

        lw_beq();
        nops(3);

        drive(0, 0, 9, 1, 0, 0, 0, 0); step();
        drive(9, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk); chk("addu stall", int'(stall), 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("addu fwd_rs_e", int'(fwd_rs_e), 1);
        nops(3);

        drive(0, 0, 31, 0, 0, 0, 0, 0); step();
        drive(31, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("jr stall", int'(stall), 0);
        chk("jr fwd_rs_d", int'(fwd_rs_d), 1);
        nops(3);

        drive(0, 0, 0, 2, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        chk("r0 stall", int'(stall), 0);
        chk("r0 fwd_rs_d", int'(fwd_rs_d), 0);
        nops(3);

        drive(0, 0, 10, 0, 0, 0, 0, 0); step();
        drive(0, 0, 10, 0, 0, 0, 0, 0); step();
        drive(10, 0, 0, 0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("m_beats_w fwd_rs_e", int'(fwd_rs_e), 1);
        nops(3);

        // Reset dropped while a stall is active.
        drive(0, 0, 8, 2, 0, 0, 0, 0); step();
        drive(8, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk); chk("pre-reset stall", int'(stall), 1);
        #2 reset = 1'b0;
        #1 chk("reset mid-stall", int'(stall), 0);
        step(); step();
        reset = 1'b1;
        nops(3);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end

        nops(2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        nops(3);
        repeat (3) lw_beq();
`ifdef HAZARD_STAT_EN
        @(negedge clk); chk("stall_cnt after 3 lw_beq", int'(stall_cnt), 6);
`endif
        nops(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
